// File: rtl/ct_fcnvt_wb_buf_pkg.sv
// Shared definitions for the fcnvt writeback buffer: fflags bit positions
// and the sideband fields carried with every buffered result.
package ct_fcnvt_wb_buf_pkg;

  localparam int FFLAG_W  = 5;
  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  // Exception sideband of a wb entry; the full entry is {data, preg, meta}.
  typedef struct packed {
    logic [FFLAG_W-1:0] expt;
    logic               expt_vld;
  } wb_meta_t;

  // Flags an entry contributes to fflags when it retires.
  function automatic logic [FFLAG_W-1:0] expt_contrib(input wb_meta_t meta);
    return meta.expt_vld ? meta.expt : '0;
  endfunction

endpackage

// File: rtl/ct_fcnvt_wb_fifo.sv
// Generic DEPTH x W FIFO with occupancy count and synchronous flush.
// Overflowing pushes (full, no pop) are dropped; pops on empty are ignored.
// Flush discards the same-cycle push and pop.
module ct_fcnvt_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & ~i_flush & (~w_full | w_do_pop);

  // Next occupancy, also used by the owner to register early backpressure.
  always_comb begin
    w_count_next = r_count;
    if (i_flush) begin
      w_count_next = '0;
    end else if (w_do_push && !w_do_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (w_do_pop && !w_do_push) begin
      w_count_next = r_count - 1'b1;
    end
  end

  assign o_count_next = w_count_next;

  // Pointers and count; pointer width makes wrap modulo DEPTH implicit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  // Entry storage; contents are qualified by the count so no reset needed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];

endmodule

// File: rtl/ct_fcnvt_wb_buf.sv
// fcnvt writeback buffer: queues EX3 convert results for the VFPU write
// port, accumulates sticky fflags at retirement and raises early stall.
// Optional macro FCNVT_WB_BYPASS_EN: an op arriving at an empty buffer with
// the write port granted is forwarded combinationally instead of queued.
module ct_fcnvt_wb_buf
  import ct_fcnvt_wb_buf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int PREG_W = 7
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              fcnvt_forward_r_vld,
  input  logic [DATA_W-1:0] fcnvt_forward_result,
  input  logic [PREG_W-1:0] fcnvt_forward_preg,
  input  logic              fcnvt_ereg_forward_r_vld,
  input  logic [4:0]        fcnvt_ereg_forward_result,
  input  logic              rtu_yy_xx_flush,
  input  logic              vfpu_wb_grant,
  input  logic              cp0_vfpu_fflags_wen,
  input  logic [4:0]        cp0_vfpu_fflags_wdata,
  output logic              fcnvt_wb_vld,
  output logic [PREG_W-1:0] fcnvt_wb_preg,
  output logic [DATA_W-1:0] fcnvt_wb_data,
  output logic [4:0]        vfpu_cp0_fflags,
  output logic              fcnvt_wb_stall
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int META_W = $bits(wb_meta_t);
  localparam int ENT_W  = DATA_W + PREG_W + META_W;

  wb_meta_t          w_push_meta;
  wb_meta_t          w_head_meta;
  logic [ENT_W-1:0]  w_push_ent;
  logic [ENT_W-1:0]  w_head_ent;
  logic [DATA_W-1:0] w_head_data;
  logic [PREG_W-1:0] w_head_preg;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_bypass;
  logic              w_push;
  logic              w_head_pop;
  logic [4:0]        w_acc;
  logic [4:0]        w_fflags_next;
  logic [4:0]        r_fflags;
  logic              r_stall;

  assign w_push_meta = '{expt: fcnvt_ereg_forward_result, expt_vld: fcnvt_ereg_forward_r_vld};
  assign w_push_ent  = {fcnvt_forward_result, fcnvt_forward_preg, w_push_meta};
  assign {w_head_data, w_head_preg, w_head_meta} = w_head_ent;

`ifdef FCNVT_WB_BYPASS_EN
  assign w_bypass = w_fifo_empty & fcnvt_forward_r_vld & ~rtu_yy_xx_flush & vfpu_wb_grant;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push     = fcnvt_forward_r_vld & ~w_bypass;
  assign w_head_pop = ~w_fifo_empty & vfpu_wb_grant & ~rtu_yy_xx_flush;

  ct_fcnvt_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk          (forever_cpuclk),
    .rst_n        (cpurst_b),
    .i_push       (w_push),
    .i_pop        (vfpu_wb_grant),
    .i_flush      (rtu_yy_xx_flush),
    .i_wdata      (w_push_ent),
    .o_rdata      (w_head_ent),
    .o_empty      (w_fifo_empty),
    .o_count_next (w_count_next)
  );

  // Write-port view: bypassed op wins, else the queue head, else zeros.
  always_comb begin
    fcnvt_wb_vld  = 1'b0;
    fcnvt_wb_preg = '0;
    fcnvt_wb_data = '0;
    if (w_bypass) begin
      fcnvt_wb_vld  = 1'b1;
      fcnvt_wb_preg = fcnvt_forward_preg;
      fcnvt_wb_data = fcnvt_forward_result;
    end else if (!w_fifo_empty) begin
      fcnvt_wb_vld  = 1'b1;
      fcnvt_wb_preg = w_head_preg;
      fcnvt_wb_data = w_head_data;
    end
  end

  // Flags retiring this cycle: popped head, bypassed op, or flag-only op.
  // A flush cancels all of them so squashed ops never raise flags.
  always_comb begin
    w_acc = '0;
    if (!rtu_yy_xx_flush) begin
      if (w_head_pop) begin
        w_acc = w_acc | expt_contrib(w_head_meta);
      end
      if (w_bypass && fcnvt_ereg_forward_r_vld) begin
        w_acc = w_acc | fcnvt_ereg_forward_result;
      end
      if (fcnvt_ereg_forward_r_vld && !fcnvt_forward_r_vld) begin
        w_acc = w_acc | fcnvt_ereg_forward_result;
      end
    end
    // A CSR write replaces the old value but never masks fresh flags.
    w_fflags_next = cp0_vfpu_fflags_wen ? (cp0_vfpu_fflags_wdata | w_acc)
                                        : (r_fflags | w_acc);
  end

  // Sticky fflags and early stall; stall leaves room for two ops in flight.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_fflags <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_fflags <= w_fflags_next;
      r_stall  <= (w_count_next >= CNT_W'(DEPTH - 2));
    end
  end

  assign vfpu_cp0_fflags = r_fflags;
  assign fcnvt_wb_stall  = r_stall;

endmodule

// File: tb/tb_ct_fcnvt_wb_buf.sv
// Self-checking bench for ct_fcnvt_wb_buf: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_ct_fcnvt_wb_buf;
  import ct_fcnvt_wb_buf_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
  localparam int PREG_W = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_vld;
  logic [DATA_W-1:0] i_data;
  logic [PREG_W-1:0] i_preg;
  logic              i_evld;
  logic [4:0]        i_expt;
  logic              i_flush;
  logic              i_grant;
  logic              i_wen;
  logic [4:0]        i_wdata;
  logic              o_vld;
  logic [PREG_W-1:0] o_preg;
  logic [DATA_W-1:0] o_data;
  logic [4:0]        o_fflags;
  logic              o_stall;

  always #5 clk = ~clk;

  ct_fcnvt_wb_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PREG_W(PREG_W)) dut (
    .forever_cpuclk            (clk),
    .cpurst_b                  (rst_n),
    .fcnvt_forward_r_vld       (i_vld),
    .fcnvt_forward_result      (i_data),
    .fcnvt_forward_preg        (i_preg),
    .fcnvt_ereg_forward_r_vld  (i_evld),
    .fcnvt_ereg_forward_result (i_expt),
    .rtu_yy_xx_flush           (i_flush),
    .vfpu_wb_grant             (i_grant),
    .cp0_vfpu_fflags_wen       (i_wen),
    .cp0_vfpu_fflags_wdata     (i_wdata),
    .fcnvt_wb_vld              (o_vld),
    .fcnvt_wb_preg             (o_preg),
    .fcnvt_wb_data             (o_data),
    .vfpu_cp0_fflags           (o_fflags),
    .fcnvt_wb_stall            (o_stall)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [PREG_W-1:0] preg;
    logic [4:0]        expt;
    logic              ev;
  } mentry_t;

  mentry_t    mq[$];
  logic [4:0] m_fflags;
  logic       m_stall;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_bypass();
    bit b = 1'b0;
`ifdef FCNVT_WB_BYPASS_EN
    b = (mq.size() == 0) && i_vld && !i_flush && i_grant;
`endif
    return b;
  endfunction

  task automatic check_outputs(input string ctx);
    logic              e_vld  = 1'b0;
    logic [PREG_W-1:0] e_preg = '0;
    logic [DATA_W-1:0] e_data = '0;
    if (exp_bypass()) begin
      e_vld = 1'b1; e_preg = i_preg; e_data = i_data;
    end else if (mq.size() > 0) begin
      e_vld = 1'b1; e_preg = mq[0].preg; e_data = mq[0].data;
    end
    chk({ctx, ".wb_vld"}, o_vld, e_vld);
    chk({ctx, ".wb_preg"}, o_preg, e_preg);
    chk({ctx, ".wb_data"}, o_data, e_data);
    chk({ctx, ".fflags"}, o_fflags, m_fflags);
    chk({ctx, ".stall"}, o_stall, m_stall);
  endtask

  task automatic model_reset();
    mq.delete();
    m_fflags = '0;
    m_stall  = 1'b0;
  endtask

  // Apply one clock edge to the model from the currently driven inputs.
  task automatic model_clock();
    logic [4:0] acc = '0;
    int   pre = mq.size();
    bit   popped = 1'b0;
    bit   byp = exp_bypass();
    mentry_t e;
    if (i_flush) begin
      mq.delete();
    end else begin
      if (pre > 0 && i_grant) begin
        if (mq[0].ev) acc |= mq[0].expt;
        void'(mq.pop_front());
        popped = 1'b1;
      end
      if (byp) begin
        if (i_evld) acc |= i_expt;
      end else if (i_vld && (pre < DEPTH || popped)) begin
        e.data = i_data; e.preg = i_preg; e.expt = i_expt; e.ev = i_evld;
        mq.push_back(e);
      end
      if (i_evld && !i_vld) acc |= i_expt;
    end
    m_fflags = i_wen ? (i_wdata | acc) : (m_fflags | acc);
    m_stall  = (mq.size() >= DEPTH - 2);
  endtask

  task automatic drive(input logic vld, input logic [DATA_W-1:0] data, input logic [PREG_W-1:0] preg,
                       input logic evld, input logic [4:0] expt, input logic grant,
                       input logic flush, input logic wen, input logic [4:0] wdata);
    i_vld = vld; i_data = data; i_preg = preg; i_evld = evld; i_expt = expt;
    i_grant = grant; i_flush = flush; i_wen = wen; i_wdata = wdata;
  endtask

  task automatic idle(input logic grant);
    drive(1'b0, '0, '0, 1'b0, '0, grant, 1'b0, 1'b0, '0);
  endtask

  // Check outputs mid-low-phase, clock the model, land on the next negedge.
  task automatic step(input string ctx);
    #1;
    check_outputs(ctx);
    $display("[TB] t=%0t %s vld=%0b grant=%0b flush=%0b -> wb_vld=%0b preg=%0d fflags=%05b stall=%0b q=%0d",
             $time, ctx, i_vld, i_grant, i_flush, o_vld, o_preg, o_fflags, o_stall, mq.size());
    model_clock();
    @(negedge clk);
  endtask

  initial begin
    idle(1'b0);
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single push with grant held high.
    drive(1'b1, 64'h3FF0000000000000, 7'd5, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    step("push1");
    idle(1'b1);
    step("push1_wb");
    step("push1_empty");
    chk("push1_drained", o_vld, 1'b0);

    // Fill to full with no grant; fifth push must be dropped.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, {32'hA5A5_0000, 32'(k)}, 7'(10 + k), 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
      step($sformatf("fill%0d", k));
      if (k == 1) chk("stall_after_2nd", o_stall, 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      chk($sformatf("drain_preg%0d", k), o_preg, 7'(10 + k));
      step($sformatf("drain%0d", k));
    end
    chk("drain_empty", o_vld, 1'b0);

    // Flags accumulate only at pop time.
    drive(1'b1, 64'h1, 7'd20, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0, '0);
    step("expt_push_a");
    drive(1'b1, 64'h2, 7'd21, 1'b1, 5'b10000, 1'b0, 1'b0, 1'b0, '0);
    step("expt_push_b");
    idle(1'b1);
    step("expt_pop_a");
    chk("fflags_mid", o_fflags, 5'b00001);
    step("expt_pop_b");
    chk("fflags_both", o_fflags, 5'b10001);

    // Clear fflags by CSR, then flush two flagged entries.
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 5'b00000);
    step("csr_clear");
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 64'(k + 100), 7'(30 + k), 1'b1, 5'b00100, 1'b0, 1'b0, 1'b0, '0);
      step($sformatf("flush_fill%0d", k));
    end
    drive(1'b1, 64'hDEAD, 7'd40, 1'b1, 5'b00010, 1'b1, 1'b1, 1'b0, '0);
    step("flush");
    chk("flush_empty", o_vld, 1'b0);
    chk("flush_fflags", o_fflags, 5'b00000);
    drive(1'b1, 64'hBEEF, 7'd41, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    step("post_flush_push");
    idle(1'b1);
    chk("post_flush_preg", o_preg, 7'd41);
    step("post_flush_pop");

    // CSR write concurrent with a flagged pop.
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 5'b00011);
    step("csr_set");
    drive(1'b1, 64'h55, 7'd50, 1'b1, 5'b01000, 1'b0, 1'b0, 1'b0, '0);
    step("csr_push");
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 5'b00000);
    step("csr_and_pop");
    chk("csr_concurrent", o_fflags, 5'b01000);

    // Push into an empty buffer with grant (bypass when enabled).
    drive(1'b1, 64'h99, 7'd9, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    step("bypass_try");
    idle(1'b1);
    step("bypass_after");

    // Flag-only op, and flag-only discarded under flush.
    drive(1'b0, '0, '0, 1'b1, 5'b00100, 1'b0, 1'b0, 1'b0, '0);
    step("flag_only");
    drive(1'b0, '0, '0, 1'b1, 5'b00010, 1'b0, 1'b1, 1'b0, '0);
    step("flag_only_flush");
    chk("flag_only_result", o_fflags, 5'b01100);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 7'($urandom),
            1'($urandom_range(0, 1)), 5'($urandom),
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 24) == 0), 5'($urandom));
      step($sformatf("rand%0d", k));
    end

    // Asynchronous reset while entries are pending.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 64'(k), 7'(60 + k), 1'b1, 5'b11111, 1'b0, 1'b0, 1'b0, '0);
      step($sformatf("pre_rst%0d", k));
    end
    idle(1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 64'h77, 7'd70, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    step("post_rst_push");
    idle(1'b1);
    step("post_rst_pop");
    step("post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ct_fcnvt_wb_buf.md
Name: ct_fcnvt_wb_buf

Overview:
- Consumer end of the fcnvt forward interface (fcnvt_forward_* result, fcnvt_ereg_forward_* exception flags).
- Buffers EX3 convert results with their destination preg in a small FIFO and drains them to the VFPU register-file write port under a valid/grant handshake.
- Accumulates exception flags into the sticky fflags register at writeback, so flushed ops never set flags.
- Sits between the fcnvt unit and the vfpu writeback arbiter; raises an early stall back to the VFALU issue stage.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 4.
- DATA_W, 64, result width.
- PREG_W, 7, destination physical register index width.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst_b  in  1  async active-low reset.
- fcnvt_forward_r_vld  in  1  EX3 result valid (push request).
- fcnvt_forward_result  in  DATA_W  EX3 result data.
- fcnvt_forward_preg  in  PREG_W  destination preg of the EX3 op.
- fcnvt_ereg_forward_r_vld  in  1  exception flags valid for the same EX3 op.
- fcnvt_ereg_forward_result  in  5  {NV,DZ,OF,UF,NX}.
- rtu_yy_xx_flush  in  1  pipeline flush.
- vfpu_wb_grant  in  1  write port accepts the head entry this cycle.
- cp0_vfpu_fflags_wen  in  1  CSR write of fflags.
- cp0_vfpu_fflags_wdata  in  5  CSR write data.
- fcnvt_wb_vld  out  1  head entry valid to write port.
- fcnvt_wb_preg  out  PREG_W  head preg.
- fcnvt_wb_data  out  DATA_W  head data.
- vfpu_cp0_fflags  out  5  sticky fflags.
- fcnvt_wb_stall  out  1  backpressure to the VFALU EX1 issue stage.

Behaviour:
- Reset: all entries invalid; count=0; rd_ptr=wr_ptr=0; fflags=0. All outputs are 0 during reset.
- Entry fields: {data, preg, expt[4:0], expt_vld}.
- Push: r_vld=1 writes an entry at wr_ptr. expt_vld = ereg_forward_r_vld. Result visible at fcnvt_wb_vld the next cycle (latency 1).
- Pop: fcnvt_wb_vld & vfpu_wb_grant advances rd_ptr. On pop, if the head's expt_vld=1, fflags |= expt.
- ereg_forward_r_vld without r_vld (flag-only op): the flags OR into fflags on the next edge, unbuffered.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy, range 0..DEPTH.
- Push and pop in the same cycle: count unchanged. This is legal when full.
- Stall: fcnvt_wb_stall = (count >= DEPTH-2), registered from next-count. Up to 2 ops in flight (EX2, EX3) still land after stall asserts.
- Overflow (push while full with no pop) is a protocol violation: the push is dropped and the FIFO is unchanged.
- Empty: fcnvt_wb_vld=0; grant is ignored.
- Flush: on the next edge all entries are invalidated, count=0, pointers=0. Same-cycle push and pop are discarded and no flags accumulate from them. Flag-only accumulation in the flush cycle is also discarded. fflags otherwise retains its value.
- CSR write: fflags <= wdata | (flags accumulated in the same cycle). Write takes priority over the old value but not over concurrent accumulation.
- Reset mid-operation: asynchronous clear to the reset state; pending entries are lost.

Optional Feature:
- Macro FCNVT_WB_BYPASS_EN.
- Defined: when the FIFO is empty, r_vld=1, no flush and vfpu_wb_grant=1, the incoming op drives fcnvt_wb_* combinationally in the same cycle and is not enqueued. Its flags accumulate on that edge. Latency 0.
- Not defined: every result passes through the FIFO; latency 1; outputs come only from registers.

Decomposition:
- Shared package: the flag bit-index constants (NV=4, DZ=3, OF=2, UF=1, NX=0) and the wb entry struct typedef.
- One natural sub-module: ct_fcnvt_wb_fifo (generic DEPTH x entry FIFO with count, flush and full/empty). The top holds the fflags logic, stall and bypass.

Test Plan:
- Push preg=5, data=0x3FF0000000000000, grant held high -> wb_vld=1 one cycle later with that preg/data; count returns to 0.
- Four pushes with grant=0 -> stall asserts after the 2nd push; count=4; fifth push is dropped; grant then drains 4 entries in order.
- Push with expt=5'b00001 then push with expt=5'b10000, grant after both -> fflags=5'b10001 only after the second pop.
- Two entries with expt=5'b00100 plus flush -> FIFO empty next cycle; fflags stays 0; a following push works from ptr 0.
- fflags=5'b00011; CSR write 5'b00000 in the same cycle as popping expt=5'b01000 -> fflags=5'b01000.
- With FCNVT_WB_BYPASS_EN, FIFO empty and grant=1, push preg=9 -> wb_vld=1 and preg=9 in the same cycle; count stays 0.
